// File: rtl/sr_latch.sv
// rtl/sr_latch.sv - clocked NAND SR latch model with forbidden-state and race flagging
module sr_latch #(
    parameter int   SYNC_STAGES = 0,
    parameter int   RACE_POLICY = 0,
    parameter logic RESET_Q     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    input  logic clr_err,
    output logic q,
    output logic qbar,
    output logic invalid,
    output logic race,
    output logic race_sticky
);

    logic ss;
    logic rs;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign ss = s;
            assign rs = r;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_sync;
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_sync <= '1;
                    r_sync <= '1;
                end else begin
                    s_sync[0] <= s;
                    r_sync[0] <= r;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        s_sync[i] <= s_sync[i-1];
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign ss = s_sync[SYNC_STAGES-1];
            assign rs = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic       last_valid;
    logic [1:0] prev_pair;
    logic       race_hit;
    logic       race_q;

    // Leaving the forbidden state straight into hold is the only race; exits to set/reset are plain writes.
    assign race_hit = (prev_pair == 2'b00) && ({ss, rs} == 2'b11);

    always_comb begin
        race_q = last_valid;
        if (RACE_POLICY == 1) begin
            race_q = 1'b0;
        end else if (RACE_POLICY == 2) begin
            race_q = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q           <= RESET_Q;
            qbar        <= ~RESET_Q;
            invalid     <= 1'b0;
            race        <= 1'b0;
            race_sticky <= 1'b0;
            last_valid  <= RESET_Q;
            prev_pair   <= 2'b11;
        end else begin
            prev_pair <= {ss, rs};
            invalid   <= 1'b0;
            race      <= 1'b0;
            case ({ss, rs})
                2'b01: begin
                    q          <= 1'b1;
                    qbar       <= 1'b0;
                    last_valid <= 1'b1;
                end
                2'b10: begin
                    q          <= 1'b0;
                    qbar       <= 1'b1;
                    last_valid <= 1'b0;
                end
                2'b00: begin
                    q       <= 1'b1;
                    qbar    <= 1'b1;
                    invalid <= 1'b1;
                end
                default: begin
                    if (race_hit) begin
                        q    <= race_q;
                        qbar <= ~race_q;
                        race <= 1'b1;
                    end
                end
            endcase
            // A race in the same cycle as a clear must leave the flag set.
            if (race_hit) begin
                race_sticky <= 1'b1;
            end else if (clr_err) begin
                race_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch.sv
// tb/tb_sr_latch.sv - bench for sr_latch across sync-depth and race-policy variants
module tb_sr_latch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic s;
    logic r;
    logic clr_err;
    logic [2:0] q_w;
    logic [2:0] qb_w;
    logic [2:0] inv_w;
    logic [2:0] race_w;
    logic [2:0] st_w;

    sr_latch #(.SYNC_STAGES(0), .RACE_POLICY(0), .RESET_Q(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
        .q(q_w[0]), .qbar(qb_w[0]), .invalid(inv_w[0]), .race(race_w[0]), .race_sticky(st_w[0])
    );
    sr_latch #(.SYNC_STAGES(0), .RACE_POLICY(2), .RESET_Q(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
        .q(q_w[1]), .qbar(qb_w[1]), .invalid(inv_w[1]), .race(race_w[1]), .race_sticky(st_w[1])
    );
    sr_latch #(.SYNC_STAGES(2), .RACE_POLICY(0), .RESET_Q(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .clr_err(clr_err),
        .q(q_w[2]), .qbar(qb_w[2]), .invalid(inv_w[2]), .race(race_w[2]), .race_sticky(st_w[2])
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Pin history indexed by edge number; a sample older than the last reset reads as idle (1,1).
    logic [1:0] pin_hist [0:4095];
    int edge_no = 0;
    int last_rst = -100;
    int stages [3] = '{0, 0, 2};
    int policy [3] = '{0, 2, 0};
    logic m_q [3];
    logic m_qb [3];
    logic m_inv [3];
    logic m_race [3];
    logic m_st [3];
    logic m_lv [3];
    logic [1:0] m_prev [3];

    task automatic model_edge();
        logic [1:0] pair;
        int idx;
        if (!rst_n) begin
            last_rst = edge_no;
            for (int k = 0; k < 3; k++) begin
                m_q[k] = 1'b0; m_qb[k] = 1'b1; m_inv[k] = 1'b0;
                m_race[k] = 1'b0; m_st[k] = 1'b0; m_lv[k] = 1'b0; m_prev[k] = 2'b11;
            end
        end else begin
            pin_hist[edge_no] = {s, r};
            for (int k = 0; k < 3; k++) begin
                idx = edge_no - stages[k];
                pair = (idx <= last_rst) ? 2'b11 : pin_hist[idx];
                m_race[k] = (m_prev[k] == 2'b00) && (pair == 2'b11);
                m_inv[k] = (pair == 2'b00);
                if (pair == 2'b01) begin
                    m_q[k] = 1'b1; m_qb[k] = 1'b0; m_lv[k] = 1'b1;
                end else if (pair == 2'b10) begin
                    m_q[k] = 1'b0; m_qb[k] = 1'b1; m_lv[k] = 1'b0;
                end else if (pair == 2'b00) begin
                    m_q[k] = 1'b1; m_qb[k] = 1'b1;
                end else if (m_race[k]) begin
                    m_q[k] = (policy[k] == 1) ? 1'b0 : (policy[k] == 2) ? 1'b1 : m_lv[k];
                    m_qb[k] = ~m_q[k];
                end
                if (m_race[k]) m_st[k] = 1'b1;
                else if (clr_err) m_st[k] = 1'b0;
                m_prev[k] = pair;
            end
        end
        edge_no++;
    endtask

    function automatic logic [4:0] outs(int k);
        return {q_w[k], qb_w[k], inv_w[k], race_w[k], st_w[k]};
    endfunction

    task automatic check_all();
        logic [4:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            exp_v = {m_q[k], m_qb[k], m_inv[k], m_race[k], m_st[k]};
            n_vec++;
            if (outs(k) !== exp_v) begin
                n_err++;
                $display("FAIL model_cmp dut%0d cycle %0d: got q,qbar,inv,race,sticky=%b required %b",
                         k, cyc, outs(k), exp_v);
            end
        end
    endtask

    task automatic lit5(input string name, input int k, input logic [4:0] exp_v);
        n_vec++;
        if (outs(k) !== exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got q,qbar,inv,race,sticky=%b required %b",
                     name, k, cyc, outs(k), exp_v);
        end
    endtask

    task automatic lit_q2(input string name, input logic exp_q);
        n_vec++;
        if (q_w[2] !== exp_q) begin
            n_err++;
            $display("FAIL %s dut2 cycle %0d: got q=%b required %b", name, cyc, q_w[2], exp_q);
        end
    endtask

    task automatic cycle(input logic ts, input logic tr, input logic tc, input logic trn);
        s = ts; r = tr; clr_err = tc; rst_n = trn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) lit5("reset", k, 5'b01000);

        cycle(0, 1, 0, 1); lit5("set", 0, 5'b10000);
        cycle(1, 1, 0, 1); lit5("hold_after_set", 0, 5'b10000);
        cycle(1, 0, 0, 1); lit5("reset_req", 0, 5'b01000);
        cycle(1, 1, 0, 1); lit5("hold_after_reset", 0, 5'b01000);

        cycle(0, 0, 0, 1); lit5("forbidden1", 0, 5'b11100);
        cycle(0, 0, 0, 1); lit5("forbidden2", 0, 5'b11100);
        cycle(1, 1, 0, 1); lit5("race_pol0", 0, 5'b01011); lit5("race_pol2", 1, 5'b10011);
        cycle(1, 1, 0, 1); lit5("race_one_cycle", 0, 5'b01001);

        cycle(0, 0, 0, 1); lit5("forbidden3", 0, 5'b11101);
        cycle(1, 0, 0, 1); lit5("non_race_exit", 0, 5'b01001);

        cycle(1, 1, 1, 1); lit5("sticky_clear", 0, 5'b01000);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 1, 1); lit5("race_beats_clr", 0, 5'b01011);
        cycle(1, 1, 1, 1); lit5("sticky_clear2", 0, 5'b01000);

        cycle(1, 0, 0, 1);
        repeat (4) cycle(1, 1, 0, 1);
        lit_q2("lat_idle", 1'b0);
        cycle(0, 1, 0, 1); lit_q2("lat_edge0", 1'b0); lit5("lat_sync0", 0, 5'b10000);
        cycle(1, 1, 0, 1); lit_q2("lat_edge1", 1'b0);
        cycle(1, 1, 0, 1); lit_q2("lat_edge2", 1'b1);

        cycle(1, 0, 0, 1);
        repeat (3) cycle(1, 1, 0, 1);
        lit_q2("pre_mid_reset", 1'b0);
        cycle(0, 1, 0, 1);
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) lit5("mid_reset", k, 5'b01000);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 1);
            lit_q2("sync_discarded", 1'b0);
        end

        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1); lit5("exit_to_set", 0, 5'b10000);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1); lit5("race_restore_1", 0, 5'b10011); lit5("race_force_1", 1, 5'b10011);
        repeat (4) cycle(1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sr_latch.md
Name: sr_latch

Overview:
- Clocked, synchronous model of a cross-coupled NAND SR latch with active-low set and reset inputs.
- Gives deterministic, simulation-safe latch behaviour, including the forbidden state and the race on leaving it.
- Flags illegal input combinations for a status block or checker.
- Sits between control logic that drives raw set/reset requests and downstream logic that consumes q/qbar.

Parameters:
- SYNC_STAGES, 0, number of input synchronizer flops on s and r (0–3). 0 means inputs are sampled directly at the clock edge.
- RACE_POLICY, 0, outcome when the inputs go from (0,0) directly to (1,1). 0 = restore last valid q, 1 = force q=0, 2 = force q=1.
- RESET_Q, 0, value loaded into q by reset.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- s  input  1  active-low set request
- r  input  1  active-low reset request
- clr_err  input  1  active-high; clears race_sticky
- q  output  1  latch output
- qbar  output  1  complementary latch output
- invalid  output  1  high while the latched inputs are the forbidden (0,0)
- race  output  1  one-cycle pulse when a (0,0)->(1,1) race is resolved
- race_sticky  output  1  sticky race indicator

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following are loaded:
  - q=RESET_Q, qbar=~RESET_Q
  - invalid=0, race=0, race_sticky=0
  - last_valid=RESET_Q
  - all synchronizer flops and the previous-input register set to 1 (inactive)
  - Reset has priority over every other action.
- Input path: s and r pass through SYNC_STAGES flops, each initialised to 1. Call the results ss and rs.
- Latency: q, qbar and invalid reflect ss/rs one clock after they are sampled. Total latency from the pins is SYNC_STAGES+1 clocks.
- Truth table on each edge, applied to the sampled (ss, rs):
  - (0,1): set. q=1, qbar=0, last_valid=1, invalid=0.
  - (1,0): reset. q=0, qbar=1, last_valid=0, invalid=0.
  - (1,1): hold. q and qbar unchanged, invalid=0, except in the race case below.
  - (0,0): forbidden. q=1, qbar=1, invalid=1. last_valid is not changed.
- Race:
  - A race occurs when the previous sampled pair was (0,0) and the current pair is (1,1).
  - Resolution per RACE_POLICY: 0 gives q=last_valid, 1 gives q=0, 2 gives q=1. qbar is always ~q.
  - race=1 for exactly that one cycle, and race_sticky is set to 1.
  - Any RACE_POLICY value other than 0, 1 or 2 behaves as 0.
- Leaving (0,0) to (0,1) or (1,0) is not a race. The normal set or reset applies and race stays 0.
- Staying in (0,0) for several cycles: invalid stays 1, and q=qbar=1 is held.
- race_sticky:
  - Set by a race and cleared by clr_err=1.
  - If a race and clr_err=1 occur in the same cycle, set wins.
- Invariant: qbar == ~q whenever invalid=0.
- The previous-input register is updated every cycle with the current sampled (ss, rs).
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with RESET_Q=0, then release → q=0, qbar=1, invalid=0, race=0, race_sticky=0.
- Set/hold/reset/hold (SYNC_STAGES=0): apply (s,r) = (0,1), (1,1), (1,0), (1,1), one clock each. Required q sequence 1,1,0,0 and qbar sequence 0,0,1,1, each one clock after the input. invalid stays 0 throughout.
- Forbidden then race: from q=0, apply (0,0) for 2 clocks, then (1,1).
  - During (0,0): q=qbar=1, invalid=1.
  - On (1,1): race=1 for one clock, race_sticky=1, q=0 (last valid under RACE_POLICY 0), qbar=1.
  - Repeat with RACE_POLICY=2: q=1 after the race.
- Non-race exit: apply (0,0) then (1,0) → q=0, qbar=1, invalid=0, race stays 0, race_sticky unchanged.
- Sticky clear and priority:
  - With race_sticky=1, pulse clr_err → race_sticky=0.
  - Force a race in the same cycle as clr_err=1 → race_sticky=1.
- Latency and mid-operation reset:
  - With SYNC_STAGES=2, apply (0,1) → q rises exactly 3 clocks later.
  - Asserting rst_n=0 mid-sequence returns all outputs to their reset values at the next edge, and the synchronizer contents are discarded.
